// File: rtl/ysyx_24100005_arb_pkg.sv
// rtl/ysyx_24100005_arb_pkg.sv - shared state/owner encodings and grant rule for the memory arbiter
package ysyx_24100005_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_t;

    // Round-robin: on a tie the master that did not win last time goes first.
    function automatic arb_owner_t pick_owner(input logic ifu_v, input logic lsu_v,
                                              input arb_owner_t last);
        if (ifu_v && lsu_v) begin
            return (last == OWN_IFU) ? OWN_LSU : OWN_IFU;
        end
        return lsu_v ? OWN_LSU : OWN_IFU;
    endfunction

endpackage

// File: rtl/ysyx_24100005_mem_arbiter_if.sv
// rtl/ysyx_24100005_mem_arbiter_if.sv - IFU/LSU/memory bundle; slave = arbiter view, master = masters+memory view
interface ysyx_24100005_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                ifu_req_valid;
    logic                ifu_req_ready;
    logic [ADDR_W-1:0]   ifu_addr;
    logic                ifu_resp_valid;
    logic [DATA_W-1:0]   ifu_rdata;
    logic                ifu_resp_err;

    logic                lsu_req_valid;
    logic                lsu_req_ready;
    logic [ADDR_W-1:0]   lsu_addr;
    logic                lsu_wen;
    logic [DATA_W-1:0]   lsu_wdata;
    logic [DATA_W/8-1:0] lsu_wmask;
    logic                lsu_resp_valid;
    logic [DATA_W-1:0]   lsu_rdata;
    logic                lsu_resp_err;

    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_wen;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wmask;
    logic                mem_resp_valid;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_resp_err;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/ysyx_24100005_arb_timer.sv
// rtl/ysyx_24100005_arb_timer.sv - watchdog counter; expired in the TIMEOUT-th enabled cycle after clr
module ysyx_24100005_arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;

    assign expired = en && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/ysyx_24100005_mem_arbiter.sv
// rtl/ysyx_24100005_mem_arbiter.sv - IFU/LSU round-robin arbiter onto one memory port, one outstanding txn
// Optional watchdog error response: YSYX_24100005_ARB_TIMEOUT_EN
module ysyx_24100005_mem_arbiter
    import ysyx_24100005_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_24100005_mem_arbiter_if.slave  bus,
    output logic                        busy
);
    arb_state_t state_q, state_d;
    arb_owner_t owner_q, last_grant_q, winner;

    logic grant_ifu, grant_lsu;
    logic accept, resp_take, timed_out, tmo_expired;

    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wmask_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

`ifdef YSYX_24100005_ARB_TIMEOUT_EN
    ysyx_24100005_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      ((state_q == ISSUE) || (state_q == WAIT)),
        .expired (tmo_expired)
    );
`else
    // No watchdog: the comparison is constant false and only keeps TIMEOUT referenced.
    assign tmo_expired = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        winner    = pick_owner(bus.ifu_req_valid, bus.lsu_req_valid, last_grant_q);
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        accept    = 1'b0;
        resp_take = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            IDLE: begin
                grant_ifu = bus.ifu_req_valid && (winner == OWN_IFU);
                grant_lsu = bus.lsu_req_valid && (winner == OWN_LSU);
                accept    = grant_ifu || grant_lsu;
                if (accept) state_d = ISSUE;
            end
            ISSUE: begin
                // Timeout wins a same-cycle ready; any later memory response lands in IDLE and is dropped.
                if (tmo_expired) begin
                    timed_out = 1'b1;
                    state_d   = RESP;
                end else if (bus.mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    resp_take = 1'b1;
                    state_d   = RESP;
                end else if (tmo_expired) begin
                    timed_out = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_LSU;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            if (accept) begin
                owner_q      <= winner;
                last_grant_q <= winner;
                if (winner == OWN_LSU) begin
                    addr_q  <= bus.lsu_addr;
                    wen_q   <= bus.lsu_wen;
                    wdata_q <= bus.lsu_wdata;
                    wmask_q <= bus.lsu_wmask;
                end else begin
                    addr_q  <= bus.ifu_addr;
                    wen_q   <= 1'b0;
                    wdata_q <= '0;
                    wmask_q <= '0;
                end
            end
            if (resp_take) begin
                rdata_q <= bus.mem_rdata;
                err_q   <= bus.mem_resp_err;
            end else if (timed_out) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign bus.ifu_req_ready  = grant_ifu;
    assign bus.lsu_req_ready  = grant_lsu;

    assign bus.mem_req_valid  = (state_q == ISSUE);
    assign bus.mem_addr       = addr_q;
    assign bus.mem_wen        = wen_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.mem_wmask      = wmask_q;

    assign bus.ifu_resp_valid = (state_q == RESP) && (owner_q == OWN_IFU);
    assign bus.lsu_resp_valid = (state_q == RESP) && (owner_q == OWN_LSU);
    assign bus.ifu_rdata      = rdata_q;
    assign bus.lsu_rdata      = rdata_q;
    assign bus.ifu_resp_err   = bus.ifu_resp_valid && err_q;
    assign bus.lsu_resp_err   = bus.lsu_resp_valid && err_q;

    assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// tb/tb_ysyx_24100005_mem_arbiter.sv - directed + randomized bench for ysyx_24100005_mem_arbiter
module tb_ysyx_24100005_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    bit   last_lsu = 1'b1;   // model: who was granted most recently

    always #5 clk = ~clk;

    ysyx_24100005_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ysyx_24100005_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_mreq"}, bus.mem_req_valid, 0);
        check({tag, "_iresp"}, bus.ifu_resp_valid, 0);
        check({tag, "_lresp"}, bus.lsu_resp_valid, 0);
    endtask

    // One full transaction: present requests, follow the winner through ISSUE/WAIT/RESP.
    task automatic txn(input bit iv, input bit lv, input logic [31:0] ia, input logic [31:0] la,
                       input bit lw, input logic [31:0] lwd, input logic [3:0] lwm,
                       input int rdly, input int sdly, input logic [31:0] rd, input bit re);
        bit          own_lsu;
        logic [31:0] ea;
        logic        ew;
        logic [3:0]  em;
        bus.ifu_req_valid = iv;  bus.ifu_addr  = ia;
        bus.lsu_req_valid = lv;  bus.lsu_addr  = la;
        bus.lsu_wen       = lw;  bus.lsu_wdata = lwd; bus.lsu_wmask = lwm;
        own_lsu = (iv && lv) ? !last_lsu : lv;
        ea = own_lsu ? la : ia;
        ew = own_lsu ? lw : 1'b0;
        em = own_lsu ? lwm : 4'h0;
        #1;
        check("ifu_ready", bus.ifu_req_ready, iv && !own_lsu);
        check("lsu_ready", bus.lsu_req_ready, own_lsu);
        check("idle_busy", busy, 0);
        step();
        last_lsu = own_lsu;
        if (own_lsu) bus.lsu_req_valid = 1'b0; else bus.ifu_req_valid = 1'b0;
        for (int d = 0; d <= rdly; d++) begin
            check("issue_valid", bus.mem_req_valid, 1);
            check("issue_addr", bus.mem_addr, ea);
            check("issue_wen", bus.mem_wen, ew);
            check("issue_wmask", bus.mem_wmask, em);
            if (own_lsu) check("issue_wdata", bus.mem_wdata, lwd);
            check("issue_rdy", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
            if (d == rdly) begin
                bus.mem_req_ready = 1'b1;
            end else if (d == 0) begin
                bus.mem_resp_valid = 1'b1; bus.mem_rdata = ~rd; bus.mem_resp_err = 1'b1;
            end
            step();
            bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
        end
        for (int s = 0; s <= sdly; s++) begin
            check("wait_mreq", bus.mem_req_valid, 0);
            check("wait_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
            check("wait_busy", busy, 1);
            if (s == sdly) begin
                bus.mem_resp_valid = 1'b1; bus.mem_rdata = rd; bus.mem_resp_err = re;
            end
            step();
            bus.mem_resp_valid = 1'b0; bus.mem_rdata = $urandom; bus.mem_resp_err = 1'b0;
        end
        check("resp_ifu_valid", bus.ifu_resp_valid, !own_lsu);
        check("resp_lsu_valid", bus.lsu_resp_valid, own_lsu);
        check("resp_rdata", own_lsu ? bus.lsu_rdata : bus.ifu_rdata, rd);
        check("resp_err", own_lsu ? bus.lsu_resp_err : bus.ifu_resp_err, re);
        step();
        check("after_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid, busy}, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_lsu = 1'b1;
    endtask

    initial begin
        bus.ifu_req_valid = 0; bus.ifu_addr = 0;
        bus.lsu_req_valid = 0; bus.lsu_addr = 0; bus.lsu_wen = 0; bus.lsu_wdata = 0; bus.lsu_wmask = 0;
        bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = 0; bus.mem_resp_err = 0;
        step();
        step();
        rst = 1'b0;
        #1;
        check_quiet("reset");
        check("reset_rdy", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
        check("reset_mem", {bus.mem_addr, bus.mem_wen, bus.mem_wmask}, 0);
        check("reset_rdata", bus.ifu_rdata, 0);

        // Both masters contending from reset: IFU first, then strict alternation.
        for (int i = 0; i < 8; i++)
            txn(1, 1, 32'h8000_0000 + 32'(i * 4), $urandom, $urandom_range(0, 1), $urandom,
                4'($urandom_range(0, 15)), 0, 0, $urandom, 0);

        // Plain IFU fetch, fastest memory.
        txn(1, 0, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 32'h0010_0073, 0);

        // LSU write with mem_req_ready held off for 5 cycles.
        txn(0, 1, 0, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'b0011, 5, 1, 32'h1234_5678, 0);

        // Memory error on an IFU read.
        txn(1, 0, 32'h8000_0040, 0, 0, 0, 0, 1, 2, 32'hCAFE_0001, 1);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(1, 3);
            txn(sel[0], sel[1], $urandom, $urandom, $urandom_range(0, 1), $urandom,
                4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom, $urandom_range(0, 1));
        end

        // Reset during WAIT; late memory response must vanish.
        bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0100;
        step();
        bus.ifu_req_valid = 0; bus.mem_req_ready = 1;
        step();
        bus.mem_req_ready = 0;
        check("rstwait_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_quiet("in_reset");
        step();
        rst = 1'b0;
        last_lsu = 1'b1;
        bus.mem_resp_valid = 1; bus.mem_rdata = 32'h5555_AAAA; bus.mem_resp_err = 1;
        step();
        bus.mem_resp_valid = 0; bus.mem_resp_err = 0;
        check_quiet("late_resp");
        check("late_rdata", {bus.ifu_rdata, bus.lsu_rdata}, 0);
        check("late_mem", {bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask}, 0);
        step();
        check_quiet("late_resp2");
        txn(1, 1, 32'h8000_0200, 32'h8000_0300, 0, 0, 0, 0, 0, 32'h0000_0013, 0);

`ifdef YSYX_24100005_ARB_TIMEOUT_EN
        // Memory never answers: error response after TO cycles in ISSUE/WAIT.
        bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0400;
        step();
        last_lsu = 1'b0;
        bus.ifu_req_valid = 0;
        for (int c = 1; c <= TO; c++) begin
            check("tmo_mreq", bus.mem_req_valid, c == 1);
            check("tmo_pending", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
            check("tmo_busy", busy, 1);
            bus.mem_req_ready = (c == 1);
            step();
            bus.mem_req_ready = 0;
        end
        check("tmo_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 2'b10);
        check("tmo_err", bus.ifu_resp_err, 1);
        check("tmo_rdata", bus.ifu_rdata, 0);
        check("tmo_mreq_drop", bus.mem_req_valid, 0);
        step();
        bus.mem_resp_valid = 1; bus.mem_rdata = 32'h7777_7777;
        #1;
        check("tmo_idle", busy, 0);
        step();
        bus.mem_resp_valid = 0;
        check_quiet("tmo_late");
`else
        // Memory never answers: arbiter stays busy until reset.
        bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0400;
        step();
        bus.ifu_req_valid = 0; bus.mem_req_ready = 1;
        step();
        bus.mem_req_ready = 0;
        for (int c = 0; c < 30; c++) begin
            if (c % 10 == 9) begin
                check("hang_busy", busy, 1);
                check("hang_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
            end
            step();
        end
        pulse_reset();
        check_quiet("hang_reset");
`endif
        txn(1, 1, 32'h8000_0500, 32'h8000_0600, 1, 32'hA5A5_5A5A, 4'hF, 0, 0, 32'h0BAD_F00D, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_24100005_mem_arbiter.md
# ysyx_24100005_mem_arbiter

Two-master, one-slave memory arbiter for the ysyx_24100005 core. Shares the single memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). Round-robin grant, one outstanding transaction, registered request capture and registered response routing. Sits between the IFU/LSU and the memory/bus bridge.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles in ISSUE+WAIT before error response (only with macro)
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- ifu_req_valid / ifu_req_ready  in / out  1  IFU request handshake
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  one-cycle response pulse to IFU
- ifu_rdata  out  DATA_W  fetched instruction
- ifu_resp_err  out  1  error flag with ifu_resp_valid
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_addr  in  ADDR_W; lsu_wen  in  1; lsu_wdata  in  DATA_W; lsu_wmask  in  DATA_W/8
- lsu_resp_valid  out  1; lsu_rdata  out  DATA_W; lsu_resp_err  out  1
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_addr  out  ADDR_W; mem_wen  out  1; mem_wdata  out  DATA_W; mem_wmask  out  DATA_W/8
- mem_resp_valid  in  1; mem_rdata  in  DATA_W; mem_resp_err  in  1
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: winner chosen combinationally; only winner's req_ready is high. Both valid: master not granted last wins. One valid: that master wins. Handshake captures addr/wen/wdata/wmask (IFU: wen=0, wmask=0) and owner; -> ISSUE; last_grant <= owner.
- ISSUE: mem_req_valid=1, mem_* driven from captured registers, stable until mem_req_ready; on mem_req_ready -> WAIT.
- WAIT: on mem_resp_valid capture rdata/err -> RESP. mem_resp_valid outside WAIT is ignored.
- RESP: owner's resp_valid=1 for exactly one cycle with captured rdata/err; other master's resp_valid=0; -> IDLE. Masters always accept responses.
- Both req_ready are 0 in ISSUE, WAIT, RESP; requests held by masters, not queued.
- Write response: lsu_resp_valid pulses, lsu_rdata = mem_rdata as returned.
- Reset values: state IDLE, last_grant LSU (IFU wins first after reset), all outputs 0, captured registers 0.
- Reset mid-transaction: transaction abandoned, no response produced; memory-side late response ignored (state IDLE).

## Timing
- Accept cycle N; mem_req_valid from N+1. mem_req_ready at N+1 -> WAIT at N+2.
- mem_resp_valid in cycle M (M>=N+2) -> resp_valid at M+1 -> IDLE at M+2; next accept earliest M+2.
- Minimum accept-to-response: 3 cycles; minimum accept-to-accept: 4 cycles.
- No combinational path from mem_* inputs to any output; req_ready depends only on state, last_grant, *_req_valid.

## Configuration
- YSYX_24100005_ARB_TIMEOUT_EN defined: counter clears on entering ISSUE, increments each cycle in ISSUE/WAIT; reaching TIMEOUT -> RESP with err=1, rdata=0, mem_req_valid dropped. Late mem response after timeout ignored.
- Not defined: no counter; ISSUE/WAIT wait indefinitely; resp_err passes mem_resp_err only.

## Structure
- Shared package ysyx_24100005_arb_pkg: state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3), owner encoding (OWN_IFU=1'b0, OWN_LSU=1'b1).
- Sub-module ysyx_24100005_arb_timer: clear/enable/expired counter, instantiated only under the macro.

## Test plan
- Reset then IFU-only read addr 0x8000_0000, mem ready immediately, resp rdata 0x0010_0073 two cycles later -> ifu_resp_valid at accept+3 with 0x0010_0073, err 0.
- IFU and LSU both valid continuously from reset -> grants alternate IFU, LSU, IFU, LSU; each gets exactly one resp pulse per grant.
- LSU write addr 0x8000_1000, wdata 0xDEAD_BEEF, wmask 4'b0011, mem_req_ready delayed 5 cycles -> mem_* stable for all 5 cycles, values match, lsu_resp_valid after response.
- Assert rst during WAIT, then deliver mem_resp_valid -> no resp pulse to either master, all outputs 0, busy 0.
- Macro on, TIMEOUT=8, memory never responds -> resp_valid with err=1, rdata 0 after 8 cycles in ISSUE/WAIT; macro off -> busy stays 1.
- mem_resp_err=1 on IFU read -> ifu_resp_err=1 with ifu_resp_valid, lsu_resp_valid stays 0.
